perceptron_trainer: RTL

Online training engine that drives the weight/bias/input side of the Perceptron neuron and consumes its output_neuron result. For each accepted labelled sample (input1, input2, target) it:
- presents the inputs to the neuron;
- waits a fixed neuron latency, then samples the prediction;
- applies the perceptron learning rule with saturating 8-bit unsigned arithmetic.
It sits between the sample source and the Perceptron instance and owns the live weight registers.

---
 rtl/perceptron_pkg.sv | 44 ++++
 rtl/perceptron_trainer_weight_update.sv | 45 ++++
 rtl/perceptron_trainer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/perceptron_pkg.sv
// Shared types, widths and saturating arithmetic for the perceptron trainer.
package perceptron_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OUT_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    UPDATE = 2'd2
  } state_e;

  // One accepted training sample, frozen at acceptance.
  typedef struct packed {
    logic [DATA_W-1:0] x1;
    logic [DATA_W-1:0] x2;
    logic              target;
    logic              train_en;
  } sample_t;

  // Live neuron parameters.
  typedef struct packed {
    logic [DATA_W-1:0] w1;
    logic [DATA_W-1:0] w2;
    logic [DATA_W-1:0] bias;
  } weights_t;

  // Unsigned add, clamped at all-ones.
  function automatic logic [DATA_W-1:0] sat_add8(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
  endfunction

  // Unsigned subtract, clamped at zero (borrow shows up in the top bit).
  function automatic logic [DATA_W-1:0] sat_sub8(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} - {1'b0, b};
    return s[DATA_W] ? {DATA_W{1'b0}} : s[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/perceptron_trainer_weight_update.sv
// Combinational perceptron learning rule.
// Ports: w_i (current weights), x1_i/x2_i (sample features), target_i, pred_i,
//        train_en_i -> w_nxt_c_o (next weights), err_c_o (pred != target).
module perceptron_weight_update
  import perceptron_pkg::*;
#(
  parameter int unsigned LR_SHIFT  = 2,
  parameter int unsigned BIAS_STEP = 1
) (
  input  weights_t          w_i,
  input  logic [DATA_W-1:0] x1_i,
  input  logic [DATA_W-1:0] x2_i,
  input  logic              target_i,
  input  logic              pred_i,
  input  logic              train_en_i,
  output weights_t          w_nxt_c_o,
  output logic              err_c_o
);

  localparam logic [DATA_W-1:0] BSTEP = DATA_W'(BIAS_STEP);

  logic [DATA_W-1:0] step1;
  logic [DATA_W-1:0] step2;

  assign step1 = x1_i >> LR_SHIFT;
  assign step2 = x2_i >> LR_SHIFT;

  // False negative pulls weights up and the threshold down; false positive the reverse.
  always_comb begin
    w_nxt_c_o = w_i;
    err_c_o   = pred_i ^ target_i;
    if (err_c_o && train_en_i) begin
      if (target_i) begin
        w_nxt_c_o.w1   = sat_add8(w_i.w1, step1);
        w_nxt_c_o.w2   = sat_add8(w_i.w2, step2);
        w_nxt_c_o.bias = sat_sub8(w_i.bias, BSTEP);
      end else begin
        w_nxt_c_o.w1   = sat_sub8(w_i.w1, step1);
        w_nxt_c_o.w2   = sat_sub8(w_i.w2, step2);
        w_nxt_c_o.bias = sat_add8(w_i.bias, BSTEP);
      end
    end
  end

endmodule

// File: rtl/perceptron_trainer.sv
// Online perceptron training engine driving an external Perceptron neuron.
// Ports: clk/reset (async active-low); in_valid/in_ready/in_x1/in_x2/in_target/
//        train_en sample handshake; load_en/load_w1/load_w2/load_bias weight
//        preload; p_input1/2, p_weight1/2, p_bias to the neuron and p_output
//        back from it; result_valid/pred/err per-sample pulse; sample_count and
//        error_count saturating statistics.
module perceptron_trainer
  import perceptron_pkg::*;
#(
  parameter int unsigned PERC_LATENCY = 2,
  parameter int unsigned LR_SHIFT     = 2,
  parameter int unsigned BIAS_STEP    = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x1,
  input  logic [DATA_W-1:0] in_x2,
  input  logic              in_target,
  input  logic              train_en,
  input  logic              load_en,
  input  logic [DATA_W-1:0] load_w1,
  input  logic [DATA_W-1:0] load_w2,
  input  logic [DATA_W-1:0] load_bias,
  output logic [DATA_W-1:0] p_input1,
  output logic [DATA_W-1:0] p_input2,
  output logic [DATA_W-1:0] p_weight1,
  output logic [DATA_W-1:0] p_weight2,
  output logic [DATA_W-1:0] p_bias,
  input  logic [OUT_W-1:0]  p_output,
  output logic              result_valid,
  output logic              result_pred,
  output logic              result_err,
  output logic [CNT_W-1:0]  sample_count,
  output logic [CNT_W-1:0]  error_count
);

  localparam int unsigned WCNT_W = 4;

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  sample_t            smp_q, smp_d;
  weights_t           w_q, w_d;
  logic               pred_q, pred_d;
  logic               rv_q, rv_d;
  logic               rp_q, rp_d;
  logic               re_q, re_d;
  logic [CNT_W-1:0]   sc_q, sc_d;
  logic [CNT_W-1:0]   ec_q, ec_d;

  weights_t           upd_w;
  logic               upd_err;

  perceptron_weight_update #(
    .LR_SHIFT  (LR_SHIFT),
    .BIAS_STEP (BIAS_STEP)
  ) u_update (
    .w_i        (w_q),
    .x1_i       (smp_q.x1),
    .x2_i       (smp_q.x2),
    .target_i   (smp_q.target),
    .pred_i     (pred_q),
    .train_en_i (smp_q.train_en),
    .w_nxt_c_o  (upd_w),
    .err_c_o    (upd_err)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      smp_q   <= '0;
      w_q     <= '0;
      pred_q  <= 1'b0;
      rv_q    <= 1'b0;
      rp_q    <= 1'b0;
      re_q    <= 1'b0;
      sc_q    <= '0;
      ec_q    <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      smp_q   <= smp_d;
      w_q     <= w_d;
      pred_q  <= pred_d;
      rv_q    <= rv_d;
      rp_q    <= rp_d;
      re_q    <= re_d;
      sc_q    <= sc_d;
      ec_q    <= ec_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    smp_d    = smp_q;
    w_d      = w_q;
    pred_d   = pred_q;
    rv_d     = 1'b0;
    rp_d     = rp_q;
    re_d     = re_q;
    sc_d     = sc_q;
    ec_d     = ec_q;
    in_ready = (state_q == IDLE) && !load_en;

    case (state_q)
      IDLE: begin
        // Preload wins over a concurrent sample; the sample simply waits.
        if (load_en) begin
          w_d = '{w1: load_w1, w2: load_w2, bias: load_bias};
        end else if (in_valid) begin
          smp_d   = '{x1: in_x1, x2: in_x2, target: in_target, train_en: train_en};
          wcnt_d  = WCNT_W'(PERC_LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wcnt_q == '0) begin
          pred_d  = (p_output != '0);
          state_d = UPDATE;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end
      UPDATE: begin
        w_d  = upd_w;
        rv_d = 1'b1;
        rp_d = pred_q;
        re_d = upd_err;
        if (sc_q != '1) sc_d = sc_q + CNT_W'(1);
        if (upd_err && (ec_q != '1)) ec_d = ec_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign p_input1     = smp_q.x1;
  assign p_input2     = smp_q.x2;
  assign p_weight1    = w_q.w1;
  assign p_weight2    = w_q.w2;
  assign p_bias       = w_q.bias;
  assign result_valid = rv_q;
  assign result_pred  = rp_q;
  assign result_err   = re_q;
  assign sample_count = sc_q;
  assign error_count  = ec_q;

endmodule
